csa_accum_30bit: RTL and testbench

- Sequential accumulation stage built around the team's combinational 30-bit carry-select adder (one csa_30bit instance).
- Accepts a burst of i_len operands over a valid/ready stream and adds each into a running 30-bit accumulator, one beat per cycle.
- Tracks carry-out as a sticky overflow flag.
- Presents the final sum downstream on a valid/ready result handshake.

---
 rtl/csa_accum_30bit_if.sv | 29 ++
 rtl/csa_accum_30bit.sv | 151 +++++++++++++++
 tb/tb_csa_accum_30bit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/csa_accum_30bit_if.sv
// Operand stream, start/length control and result handshake of the
// 30-bit carry-select accumulator, bundled as one interface.
interface csa_accum_30bit_if #(
  parameter int WIDTH = 30,
  parameter int CNT_W = 8
);
  logic             i_start;
  logic [CNT_W-1:0] i_len;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_data;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_sum;
  logic             o_ovf;
  logic             o_busy;

  // Producer/consumer side: drives start, operands and result acceptance
  modport master (
    output i_start, i_len, i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_sum, o_ovf, o_busy
  );

  // Accumulator side
  modport slave (
    input  i_start, i_len, i_valid, i_data, i_ready,
    output o_ready, o_valid, o_sum, o_ovf, o_busy
  );
endinterface

// File: rtl/csa_accum_30bit.sv
// Burst accumulator: sums i_len operands through a combinational
// carry-select adder, tracks a sticky carry-out and hands the result
// downstream on a valid/ready handshake.

// Combinational carry-select adder: block 0 ripples, every later block
// precomputes both carry-in cases and selects on the incoming carry.
module csa_30bit #(
  parameter int WIDTH = 30,
  parameter int BLK   = 6
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NB = WIDTH / BLK;

  logic [NB:0] carry;

  assign carry[0] = cin;

  for (genvar k = 0; k < NB; k++) begin : g_blk
    logic [BLK:0] s0;
    logic [BLK:0] s1;

    assign s0 = {1'b0, a[k*BLK +: BLK]} + {1'b0, b[k*BLK +: BLK]};
    assign s1 = {1'b0, a[k*BLK +: BLK]} + {1'b0, b[k*BLK +: BLK]} + {{BLK{1'b0}}, 1'b1};
    assign sum[k*BLK +: BLK] = carry[k] ? s1[BLK-1:0] : s0[BLK-1:0];
    assign carry[k+1]        = carry[k] ? s1[BLK]     : s0[BLK];
  end

  assign cout = carry[NB];
endmodule

module csa_accum_30bit #(
  parameter int WIDTH = 30,
  parameter int CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  csa_accum_30bit_if.slave     bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic             ovf, ovf_n;
  logic [CNT_W-1:0] remaining, remaining_n;
  logic             ready_q, ready_n;
  logic             valid_q, valid_n;
  logic             busy_q, busy_n;

  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             beat;

  csa_30bit #(.WIDTH(WIDTH)) u_add (
    .a    (acc),
    .b    (bus.i_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign beat = bus.i_valid && ready_q;

  // Next-state and next-register values; every target defaults to hold
  always_comb begin
    state_n     = state;
    acc_n       = acc;
    ovf_n       = ovf;
    remaining_n = remaining;
    ready_n     = ready_q;
    valid_n     = valid_q;
    case (state)
      IDLE: begin
        if (bus.i_start) begin
          acc_n = '0;
          ovf_n = 1'b0;
          if (bus.i_len != CNT_ZERO) begin
            remaining_n = bus.i_len;
            ready_n     = 1'b1;
            state_n     = ACCUM;
          end else begin
            valid_n = 1'b1;
            state_n = DONE;
          end
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_n       = add_sum;
          ovf_n       = ovf | add_cout;
          remaining_n = remaining - CNT_ONE;
          if (remaining == CNT_ONE) begin
            ready_n = 1'b0;
            valid_n = 1'b1;
            state_n = DONE;
          end
        end
      end
      DONE: begin
        if (bus.i_ready) begin
          valid_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        ready_n = 1'b0;
        valid_n = 1'b0;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      acc       <= '0;
      ovf       <= 1'b0;
      remaining <= '0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      ovf       <= ovf_n;
      remaining <= remaining_n;
      ready_q   <= ready_n;
      valid_q   <= valid_n;
      busy_q    <= busy_n;
    end
  end

  assign bus.o_ready = ready_q;
  assign bus.o_valid = valid_q;
  assign bus.o_sum   = acc;
  assign bus.o_ovf   = ovf;
  assign bus.o_busy  = busy_q;
endmodule

// File: tb/tb_csa_accum_30bit.sv
// Bench for csa_accum_30bit: directed bursts plus randomized bursts with
// bubbles and backpressure, checked against an arithmetic reference.
module tb_csa_accum_30bit;
  localparam int WIDTH = 30;
  localparam int CNT_W = 8;
  localparam longint unsigned MODV = 64'd1 << WIDTH;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  csa_accum_30bit_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  csa_accum_30bit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [WIDTH-1:0] beats[$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check_val({tag, "_ready"}, 64'(bus.o_ready), 64'd0);
    check_val({tag, "_valid"}, 64'(bus.o_valid), 64'd0);
    check_val({tag, "_sum"},   64'(bus.o_sum),   64'd0);
    check_val({tag, "_ovf"},   64'(bus.o_ovf),   64'd0);
    check_val({tag, "_busy"},  64'(bus.o_busy),  64'd0);
  endtask

  // Runs one burst from the queue 'beats'; max_gap bounds random bubbles,
  // hold is the number of cycles the result is back-pressured.
  task automatic run_burst(input int max_gap, input int hold, input bit poke_start);
    longint unsigned exp_acc = 0;
    bit              exp_ovf = 1'b0;
    int              len     = beats.size();
    int              gap;

    foreach (beats[i]) begin
      if (exp_acc + longint'(beats[i]) >= MODV) exp_ovf = 1'b1;
      exp_acc = (exp_acc + longint'(beats[i])) % MODV;
    end

    bus.i_start = 1'b1;
    bus.i_len   = CNT_W'(len);
    tick();
    bus.i_start = 1'b0;
    bus.i_len   = CNT_W'($urandom);
    check_val("busy_after_start", 64'(bus.o_busy), 64'd1);

    for (int i = 0; i < len; i++) begin
      gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      for (int g = 0; g < gap; g++) begin
        bus.i_valid = 1'b0;
        bus.i_data  = WIDTH'($urandom);
        tick();
      end
      check_val("ready_in_burst", 64'(bus.o_ready), 64'd1);
      check_val("valid_in_burst", 64'(bus.o_valid), 64'd0);
      bus.i_valid = 1'b1;
      bus.i_data  = beats[i];
      tick();
    end

    // Keep offering junk beats: none may be taken once the burst is complete
    bus.i_valid = 1'b1;
    bus.i_data  = WIDTH'($urandom);
    check_val("res_valid", 64'(bus.o_valid), 64'd1);
    check_val("res_ready", 64'(bus.o_ready), 64'd0);
    check_val("res_sum",   64'(bus.o_sum),   64'(exp_acc));
    check_val("res_ovf",   64'(bus.o_ovf),   64'(exp_ovf));

    for (int h = 0; h < hold; h++) begin
      bus.i_start = poke_start && (h == hold / 2);
      bus.i_data  = WIDTH'($urandom);
      tick();
      check_val("hold_valid", 64'(bus.o_valid), 64'd1);
      check_val("hold_sum",   64'(bus.o_sum),   64'(exp_acc));
      check_val("hold_ovf",   64'(bus.o_ovf),   64'(exp_ovf));
      check_val("hold_busy",  64'(bus.o_busy),  64'd1);
    end

    // Result handshake; a start in this same cycle must be ignored
    bus.i_ready = 1'b1;
    bus.i_start = poke_start;
    tick();
    bus.i_ready = 1'b0;
    bus.i_start = 1'b0;
    bus.i_valid = 1'b0;
    check_val("post_valid", 64'(bus.o_valid), 64'd0);
    check_val("post_busy",  64'(bus.o_busy),  64'd0);
    check_val("post_sum",   64'(bus.o_sum),   64'(exp_acc));
    check_val("post_ovf",   64'(bus.o_ovf),   64'(exp_ovf));
    tick();
    check_val("idle_busy",  64'(bus.o_busy),  64'd0);
    check_val("idle_ready", 64'(bus.o_ready), 64'd0);
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_len   = '0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_ready = 1'b0;

    // Reset for two cycles, then no activity without start
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_idle_zero("reset");
    bus.i_valid = 1'b1;
    bus.i_data  = 30'h123;
    repeat (3) tick();
    bus.i_valid = 1'b0;
    check_idle_zero("no_start");

    // Basic burst, back-to-back
    beats = '{30'd1, 30'd2, 30'd3};
    run_burst(0, 0, 1'b0);

    // Overflow wrap, then sticky flag cleared by the next start
    beats = '{30'h3FFFFFFF, 30'h00000002};
    run_burst(0, 2, 1'b0);
    beats = '{30'd5};
    run_burst(0, 0, 1'b0);

    // Bubbles and backpressure with a start poked during the wait
    beats = '{30'd10, 30'd20, 30'd30, 30'd40};
    run_burst(3, 5, 1'b1);

    // Empty burst
    beats = {};
    run_burst(0, 1, 1'b0);

    // Reset in the middle of a burst
    bus.i_start = 1'b1;
    bus.i_len   = 8'd5;
    tick();
    bus.i_start = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_data  = 30'd100;
    tick();
    bus.i_data  = 30'd200;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_zero("mid_reset");
    bus.i_valid = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    check_idle_zero("after_mid_reset");
    beats = '{30'd7, 30'd8};
    run_burst(0, 0, 1'b0);

    // Maximum-length burst, back-to-back
    beats = {};
    for (int i = 0; i < 255; i++) beats.push_back(WIDTH'($urandom));
    run_burst(0, 1, 1'b0);

    // Randomized bursts, biased toward large operands to exercise carries
    for (int t = 0; t < 25; t++) begin
      int len;
      logic [WIDTH-1:0] d;
      beats = {};
      len = $urandom_range(0, 12);
      for (int i = 0; i < len; i++) begin
        d = WIDTH'($urandom);
        if ($urandom_range(0, 1) == 1) d = d | 30'h3FFF0000;
        beats.push_back(d);
      end
      run_burst($urandom_range(0, 3), $urandom_range(0, 4), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
